// File: rtl/vec_alu_pkg.sv
// Shared op encoding for the vector/scalar EX-stage ALU and its control.
package vec_alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_ADDS = 3'd5;
  localparam logic [OP_W-1:0] OP_SUBS = 3'd6;
  localparam logic [OP_W-1:0] OP_SLTU = 3'd7;

endpackage

// File: rtl/vec_alu_lane.sv
// One combinational ALU slice of arbitrary width; used per SIMD lane and for scalar mode.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y_c
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // Top bit of each extended result is carry-out / borrow respectively.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y_c = w_sum[WIDTH-1:0];
    case (i_op)
      OP_ADD:  o_y_c = w_sum[WIDTH-1:0];
      OP_SUB:  o_y_c = w_diff[WIDTH-1:0];
      OP_AND:  o_y_c = i_a & i_b;
      OP_OR:   o_y_c = i_a | i_b;
      OP_XOR:  o_y_c = i_a ^ i_b;
      OP_ADDS: o_y_c = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
      OP_SUBS: o_y_c = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
      OP_SLTU: o_y_c = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
      default: o_y_c = w_sum[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage EX ALU: LANES-wide SIMD or full-width scalar, valid/ready handshake with flush.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           op,
  input  logic                      vect,
  input  logic                      imm_sel,
  input  logic [LANES*LANE_W-1:0]   a,
  input  logic [LANES*LANE_W-1:0]   b,
  input  logic [LANE_W-1:0]         imm,
  input  logic [TAG_W-1:0]          tag_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   result,
  output logic                      zero,
  output logic [LANES-1:0]          lane_zero,
  output logic [TAG_W-1:0]          tag_out
);

  localparam int unsigned W = LANES * LANE_W;

  logic            r_v1;
  logic [OP_W-1:0] r_op;
  logic            r_vect;
  logic [TAG_W-1:0] r_tag1;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;

  logic            r_v2;
  logic [W-1:0]    r_result;
  logic            r_zero;
  logic [LANES-1:0] r_lane_zero;
  logic [TAG_W-1:0] r_tag2;

  logic            w_adv1;
  logic            w_adv2;
  logic [W-1:0]    w_bsel;
  logic [W-1:0]    w_vec;
  logic [W-1:0]    w_scl;
  logic [W-1:0]    w_res;
  logic [LANES-1:0] w_lane_zero;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  // Immediate is broadcast per lane in SIMD mode, zero-extended in scalar mode.
  assign w_bsel = imm_sel ? (vect ? {LANES{imm}} : W'(imm)) : b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vec_alu_lane #(.WIDTH(LANE_W)) u_lane (
      .i_op  (r_op),
      .i_a   (r_a[k*LANE_W +: LANE_W]),
      .i_b   (r_b[k*LANE_W +: LANE_W]),
      .o_y_c (w_vec[k*LANE_W +: LANE_W])
    );
    assign w_lane_zero[k] = ~|w_res[k*LANE_W +: LANE_W];
  end

  vec_alu_lane #(.WIDTH(W)) u_scalar (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_y_c (w_scl)
  );

  assign w_res = r_vect ? w_vec : w_scl;

  // Stage 1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_op   <= '0;
      r_vect <= 1'b0;
      r_tag1 <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      if (flush) begin
        r_v1 <= 1'b0;
      end else if (w_adv1) begin
        r_v1 <= in_valid;
      end
      if (w_adv1 && in_valid) begin
        r_op   <= op;
        r_vect <= vect;
        r_tag1 <= tag_in;
        r_a    <= a;
        r_b    <= w_bsel;
      end
    end
  end

  // Stage 2: result register; outputs come straight from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2        <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_lane_zero <= '1;
      r_tag2      <= '0;
    end else begin
      if (flush) begin
        r_v2 <= 1'b0;
      end else if (w_adv2) begin
        r_v2 <= r_v1;
      end
      if (w_adv2 && r_v1) begin
        r_result    <= w_res;
        r_zero      <= ~|w_res;
        r_lane_zero <= w_lane_zero;
        r_tag2      <= r_tag1;
      end
    end
  end

  assign out_valid = r_v2;
  assign result    = r_result;
  assign zero      = r_zero;
  assign lane_zero = r_lane_zero;
  assign tag_out   = r_tag2;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Randomized and directed bench for vec_alu_pipe against an arithmetic reference model.
module tb_vec_alu_pipe;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned W      = LANES * LANE_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic              vect;
  logic              imm_sel;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [LANE_W-1:0] imm;
  logic [TAG_W-1:0]  tag_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      result;
  logic              zero;
  logic [LANES-1:0]  lane_zero;
  logic [TAG_W-1:0]  tag_out;

  vec_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .vect      (vect),
    .imm_sel   (imm_sel),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lane_zero (lane_zero),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic over a given width.
  function automatic longint unsigned alu_w(input int opc, input longint unsigned x,
                                            input longint unsigned y, input int unsigned w);
    longint unsigned m = (64'd1 << w) - 64'd1;
    case (opc)
      0: return (x + y) & m;
      1: return (x - y) & m;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return (x + y > m) ? m : x + y;
      6: return (x < y) ? 64'd0 : x - y;
      default: return (x < y) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input int opc, input bit vec, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    if (!vec) begin
      r = W'(alu_w(opc, 64'(x), 64'(y), W));
    end else begin
      for (int k = 0; k < int'(LANES); k++)
        r[k*LANE_W +: LANE_W] = LANE_W'(alu_w(opc, 64'(x[k*LANE_W +: LANE_W]),
                                              64'(y[k*LANE_W +: LANE_W]), LANE_W));
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bsel_of(input bit isel, input bit vec, input logic [W-1:0] bb,
                                           input logic [LANE_W-1:0] im);
    logic [W-1:0] r;
    r = bb;
    if (isel) begin
      r = '0;
      if (vec) begin
        for (int k = 0; k < int'(LANES); k++) r[k*LANE_W +: LANE_W] = im;
      end else begin
        r[LANE_W-1:0] = im;
      end
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0] lz_of(input logic [W-1:0] r);
    logic [LANES-1:0] z;
    for (int k = 0; k < int'(LANES); k++) z[k] = (r[k*LANE_W +: LANE_W] == '0);
    return z;
  endfunction

  typedef struct {
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  exp_t sb_n;

  // Scoreboard: observe both handshakes at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'd0);
          end else begin
            sb_e = sb.pop_front();
            check("sb_result", 64'(result), 64'(sb_e.res));
            check("sb_tag", 64'(tag_out), 64'(sb_e.tag));
            check("sb_zero", 64'(zero), 64'(sb_e.res == '0));
            check("sb_lane_zero", 64'(lane_zero), 64'(lz_of(sb_e.res)));
          end
        end
        if (in_valid && in_ready) begin
          sb_n.res = model(int'(op), vect, a, bsel_of(imm_sel, vect, b, imm));
          sb_n.tag = tag_in;
          sb.push_back(sb_n);
        end
      end
    end
  end

  task automatic put(input logic [2:0] o, input logic v, input logic s, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input logic [LANE_W-1:0] im, input logic [TAG_W-1:0] t);
    op = o; vect = v; imm_sel = s; a = aa; b = bb; imm = im; tag_in = t;
  endtask

  task automatic rnd_put(input logic [TAG_W-1:0] t);
    put(3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
        W'({$urandom, $urandom}), W'({$urandom, $urandom}), LANE_W'($urandom), t);
  endtask

  // Holds in_valid until the op is accepted; returns #1 after the accepting edge.
  task automatic offer();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
    end
    if (!acc) check("offer_timeout", 64'd0, 64'd1);
  endtask

  task automatic dir(input string nm, input logic [2:0] o, input logic v, input logic s,
                     input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [LANE_W-1:0] im,
                     input logic [W-1:0] er, input logic [LANES-1:0] elz);
    out_ready = 1'b1;
    put(o, v, s, aa, bb, im, 4'hA);
    offer();
    in_valid = 1'b0;
    check({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_result"}, 64'(result), 64'(er));
    check({nm, "_lane_zero"}, 64'(lane_zero), 64'(elz));
    check({nm, "_zero"}, 64'(zero), 64'(er == '0));
    @(posedge clk); #1;
  endtask

  int acc_n;
  int idx;
  bit acc;
  bit fl;
  logic [TAG_W-1:0] tg;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    put(3'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_lane_zero", 64'(lane_zero), 64'hF);
    check("rst_tag", 64'(tag_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    dir("vadd",  3'd0, 1'b1, 1'b0, 32'hFF01_7F80, 32'h0101_0180, 8'h00, 32'h0002_8000, 4'b1001);
    dir("vadds", 3'd5, 1'b1, 1'b1, 32'hF0F0_0010, 32'h1234_5678, 8'h20, 32'hFFFF_2030, 4'b0000);
    dir("vsubs", 3'd6, 1'b1, 1'b1, 32'h1000_3000, 32'h1234_5678, 8'h20, 32'h0000_1000, 4'b1101);
    dir("ssub",  3'd1, 1'b0, 1'b0, 32'h0, 32'h1, 8'h00, 32'hFFFF_FFFF, 4'b0000);
    dir("ssltu", 3'd7, 1'b0, 1'b0, 32'h5, 32'h7, 8'h00, 32'h0000_0001, 4'b1110);
    dir("simm",  3'd0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 8'h80, 32'h0000_0080, 4'b1110);
    dir("sadd",  3'd0, 1'b0, 1'b0, 32'h0000_00FF, 32'h1, 8'h00, 32'h0000_0100, 4'b1101);

    // Stall: consumer blocked, only two ops fit.
    out_ready = 1'b0;
    acc_n = 0; idx = 0;
    rnd_put(TAG_W'(idx));
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin acc_n++; idx++; rnd_put(TAG_W'(idx)); end
    end
    check("stall_accepts", 64'(acc_n), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; rnd_put(TAG_W'(idx)); end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_accept_total", 64'(idx), 64'd8);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Flush with both stages full, new op offered and consumer ready.
    out_ready = 1'b0;
    rnd_put(4'h3); offer();
    rnd_put(4'h4); offer();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    rnd_put(4'h5);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("fl_out_valid2", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fl_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with ops in flight.
    out_ready = 1'b0;
    rnd_put(4'h6); offer();
    rnd_put(4'h7); offer();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_zero", 64'(zero), 64'd1);
    check("arst_tag", 64'(tag_out), 64'd0);
    check("arst_lane_zero", 64'(lane_zero), 64'hF);
    sb.delete();
    out_ready = 1'b1;
    #10;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_output", 64'(out_valid), 64'd0);

    // Random traffic with back-pressure and occasional flush.
    tg = '0;
    in_valid = 1'b1; rnd_put(tg);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready && !flush;
      fl = flush;
      @(posedge clk); #1;
      if (!in_valid || acc || fl) begin
        tg = tg + 1'b1;
        in_valid = ($urandom_range(0, 3) != 0);
        rnd_put(tg);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained", 64'(sb.size()), 64'd0);
    check("rand_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
